// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the fetch stage: FSM encodings, instruction field
// positions and the default reset PC.
package instr_fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

endpackage

// File: rtl/instr_fetch_unit_pc_reg.sv
// Program counter register: synchronous reset, redirect load (highest
// priority after reset) and sequential increment.
module pc_reg #(
  parameter int          ADDR_W   = 16,
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          PC_STEP  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  // NOTE: state is written with non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (reset)
      pc <= ADDR_W'(RESET_PC);
    else if (load)
      pc <= load_val;
    else if (inc)
      pc <= pc + ADDR_W'(PC_STEP);  // wraps modulo 2^ADDR_W
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: req/ack instruction fetch, instruction register, and
// branch/jump redirect handling. opcode/imm8 are direct slices of instr.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int          ADDR_W   = 16,
  parameter logic [15:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          PC_STEP  = 2
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [15:0]       instr,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc_out,
  output logic [3:0]        opcode,
  output logic [7:0]        imm8
);

  fetch_state_t state, state_next;
  logic [ADDR_W-1:0] pc;
  logic req_gap;      // one-cycle request drop after redirecting a live request
  logic ack_taken;
  logic pc_inc;
  logic ir_load;
  logic valid_clr;

  pc_reg #(
    .ADDR_W  (ADDR_W),
    .RESET_PC(RESET_PC),
    .PC_STEP (PC_STEP)
  ) u_pc_reg (
    .clk     (clk),
    .reset   (reset),
    .load    (redirect),
    .load_val(redirect_pc),
    .inc     (pc_inc),
    .pc      (pc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      req_gap <= 1'b0;
    end else begin
      state   <= state_next;
      req_gap <= redirect && mem_req;
    end
  end

  // mem_ack only counts while a request is actually on the bus.
  assign ack_taken = mem_req && mem_ack;

  always_comb begin
    // NOTE: default first so every path assigns state_next; no latch.
    state_next = state;
    case (state)
      IDLE:    state_next = REQ;
      REQ:     if (!redirect && ack_taken) state_next = HOLD;
      HOLD:    if (redirect || !stall) state_next = REQ;
      default: state_next = IDLE;
    endcase
    if (redirect) state_next = REQ;
  end

  always_comb begin
    mem_req   = (state == REQ) && !req_gap;
    ir_load   = (state == REQ) && ack_taken && !redirect;
    pc_inc    = (state == HOLD) && !stall && !redirect;
    valid_clr = redirect || pc_inc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr       <= 16'h0000;
      pc_out      <= '0;
      instr_valid <= 1'b0;
    end else if (ir_load) begin
      instr       <= mem_rdata;
      pc_out      <= pc;
      instr_valid <= 1'b1;
    end else if (valid_clr) begin
      instr_valid <= 1'b0;
    end
  end

  assign mem_addr = pc;
  assign opcode   = instr[OPC_HI:OPC_LO];
  assign imm8     = instr[IMM_HI:IMM_LO];

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage of the 16-bit multicycle processor.
- Holds the PC and requests instruction words from instruction memory over a req/ack handshake.
- Latches each returned word into an instruction register and presents it, with its PC, to decode.
- Drives the 8-bit immediate field straight into sign_extend (imm8 -> in_bit_string) and handles branch/jump redirects.

Parameters:
- ADDR_W, 16, PC and memory address width.
- RESET_PC, 16'h0000, PC value loaded on reset.
- PC_STEP, 2, byte increment between sequential instructions.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- mem_req  out  1  fetch request to instruction memory.
- mem_addr  out  ADDR_W  fetch address; equals current PC.
- mem_ack  in  1  memory completion; mem_rdata valid in the same cycle.
- mem_rdata  in  16  instruction word from memory.
- stall  in  1  decode not ready; holds the current instruction.
- redirect  in  1  taken branch/jump.
- redirect_pc  in  ADDR_W  target address.
- instr  out  16  instruction register.
- instr_valid  out  1  instr/pc_out hold a live instruction.
- pc_out  out  ADDR_W  address of instr.
- opcode  out  4  instr[15:12].
- imm8  out  8  instr[7:0]; feeds sign_extend.

Behaviour:
- All state changes on rising clk. reset takes priority over every other input.
- Reset values: state IDLE, pc RESET_PC, mem_req 0, mem_addr RESET_PC, instr 16'h0000, instr_valid 0, pc_out 16'h0000. opcode and imm8 therefore read 0.
- States:
  - IDLE: no request. Goes to REQ on the next clock unconditionally.
  - REQ: mem_req=1, mem_addr=pc, both held stable until mem_ack. When mem_ack=1: instr<=mem_rdata, pc_out<=pc, instr_valid<=1, go to HOLD. While mem_ack=0, stay in REQ.
  - HOLD: mem_req=0; instr, pc_out and instr_valid=1 stable. When stall=0: the instruction is consumed at that edge, pc<=pc+PC_STEP, instr_valid<=0, go to REQ. When stall=1: remain in HOLD.
- Latency: instr_valid rises on the first edge after the mem_ack cycle. A request in REQ with zero-wait ack gives peak throughput of one instruction per 2 cycles.
- opcode and imm8 are combinational slices of instr. There is no extra delay into sign_extend.
- Redirect, in any non-reset state: pc<=redirect_pc, instr_valid<=0, go to REQ. mem_req drops for one cycle only if it was already high (clean new request).
  - redirect overrides a simultaneous mem_ack; that word is discarded and instr is unchanged.
  - redirect overrides stall.
- Wrap-around: pc arithmetic is modulo 2^ADDR_W (16'hFFFE + 2 -> 16'h0000). No flag is raised.
- Odd redirect_pc is accepted as-is; alignment is the branch unit's responsibility.
- mem_ack while mem_req=0 is ignored.
- Reset mid-request abandons the outstanding fetch: mem_req is 0 on the first post-reset cycle, and the memory must tolerate the abandoned request.
- stall has no effect outside HOLD.

Decomposition:
- Shared package: state encodings (IDLE, REQ, HOLD), field positions OPC_HI=15/OPC_LO=12, IMM_HI=7/IMM_LO=0, default RESET_PC.
- One sub-module, pc_reg: ADDR_W register with synchronous reset, load (redirect, priority) and increment-by-PC_STEP enables.
- FSM and instruction register stay in instr_fetch_unit.

Test Plan:
- Reset, then ack one cycle after each req with mem_rdata 16'h12F0 -> mem_addr 0x0000, instr 0x12F0, opcode 0x1, imm8 0xF0, instr_valid high 1 cycle after ack.
- Three sequential fetches, no stall, ack=1 whenever req -> mem_addr 0x0000, 0x0002, 0x0004; instr_valid pulses every 2 cycles.
- Hold stall=1 for 5 cycles in HOLD -> instr and pc_out unchanged, mem_req stays 0; after stall=0, next mem_addr = pc_out+2.
- redirect=1 with redirect_pc 0x0040 on the same edge as mem_ack with data 0xBEEF -> 0xBEEF never appears on instr; next mem_addr 0x0040, instr_valid 0.
- Redirect to 0xFFFE, fetch and consume -> next mem_addr 0x0000.
- Assert reset while in REQ with mem_ack withheld -> next cycle mem_req 0, mem_addr 0x0000, instr_valid 0; fetch restarts from IDLE.
